// File: rtl/nr_alu.sv
// nanoRisk registered 8-bit ALU with an independent registered address/PC adder.
// All outputs are registered: one cycle latency, held while en is low.
module nr_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [3:0]       alo,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [WIDTH-1:0] out0,
    output logic             zero,
    output logic [1:0]       ovrflw,
    output logic [WIDTH-1:0] add_out
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_PASS = 4'd11,
        OP_INC  = 4'd12,
        OP_DEC  = 4'd13
    } op_e;

    logic [WIDTH-1:0] r_out0;
    logic             r_zero;
    logic [1:0]       r_ovrflw;
    logic [WIDTH-1:0] r_addOut;

    logic [WIDTH-1:0] w_opB;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_result;
    logic [1:0]       w_flags;
    logic [WIDTH-1:0] w_addSum;

    // INC/DEC reuse the ADD/SUB datapath with operand B forced to one.
    always_comb begin
        w_opB    = ((alo == OP_INC) || (alo == OP_DEC)) ? ONE : in1;
        w_sum    = {1'b0, in0} + {1'b0, w_opB};
        w_diff   = {1'b0, in0} - {1'b0, w_opB};
        w_shamt  = in1[SHW-1:0];
        w_result = '0;
        w_flags  = 2'b00;
        case (op_e'(alo))
            OP_ADD, OP_INC: begin
                w_result = w_sum[WIDTH-1:0];
                w_flags  = {(in0[WIDTH-1] == w_opB[WIDTH-1]) && (w_sum[WIDTH-1] != in0[WIDTH-1]),
                            w_sum[WIDTH]};
            end
            OP_SUB, OP_DEC: begin
                w_result = w_diff[WIDTH-1:0];
                w_flags  = {(in0[WIDTH-1] != w_opB[WIDTH-1]) && (w_diff[WIDTH-1] != in0[WIDTH-1]),
                            w_diff[WIDTH]};
            end
            OP_AND:  w_result = in0 & in1;
            OP_OR:   w_result = in0 | in1;
            OP_XOR:  w_result = in0 ^ in1;
            OP_NOT:  w_result = ~in0;
            OP_SLL:  w_result = in0 << w_shamt;
            OP_SRL:  w_result = in0 >> w_shamt;
            OP_SRA:  w_result = $unsigned($signed(in0) >>> w_shamt);
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, $signed(in0) < $signed(in1)};
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, in0 < in1};
            OP_PASS: w_result = in1;
            default: w_result = '0;
        endcase
        w_addSum = add_a + add_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out0   <= '0;
            r_zero   <= 1'b1;
            r_ovrflw <= 2'b00;
            r_addOut <= '0;
        end else if (en) begin
            r_out0   <= w_result;
            r_zero   <= (w_result == '0);
            r_ovrflw <= w_flags;
            r_addOut <= w_addSum;
        end
    end

    assign out0    = r_out0;
    assign zero    = r_zero;
    assign ovrflw  = r_ovrflw;
    assign add_out = r_addOut;

endmodule

// File: tb/tb_nr_alu.sv
// Scoreboard bench for nr_alu: the driver pushes the expected register state for
// every clock edge; the monitor pops and compares one entry after each edge.
module tb_nr_alu;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in0, in1, add_a, add_b;
    logic [3:0] alo;
    logic [7:0] out0, add_out;
    logic       zero;
    logic [1:0] ovrflw;

    typedef struct {
        int unsigned res;
        int unsigned zf;
        int unsigned ovf;
        int unsigned addRes;
    } exp_t;

    exp_t model;
    exp_t scoreQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    nr_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in0(in0), .in1(in1), .alo(alo),
        .add_a(add_a), .add_b(add_b),
        .out0(out0), .zero(zero), .ovrflw(ovrflw), .add_out(add_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int toSigned(int unsigned v);
        return (v >= 128) ? int'(v) - 256 : int'(v);
    endfunction

    // Reference behaviour written as plain integer arithmetic on the operand values.
    function automatic exp_t refModel(int unsigned op, int unsigned a, int unsigned b,
                                      int unsigned aa, int unsigned ab);
        exp_t e;
        int   sa, sb, sr, sh;
        e.res = 0; e.ovf = 0;
        if (op == 12) b = 1;
        if (op == 13) b = 1;
        sa = toSigned(a);
        sb = toSigned(b);
        sh = int'(b % 8);
        case (op)
            0, 12: begin
                e.res = (a + b) % 256;
                sr    = sa + sb;
                e.ovf = ((sr > 127 || sr < -128) ? 2 : 0) + ((a + b > 255) ? 1 : 0);
            end
            1, 13: begin
                e.res = (a + 256 - b) % 256;
                sr    = sa - sb;
                e.ovf = ((sr > 127 || sr < -128) ? 2 : 0) + ((a < b) ? 1 : 0);
            end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = a ^ b;
            5: e.res = 255 - a;
            6: e.res = (a << sh) % 256;
            7: e.res = a >> sh;
            8: e.res = int'(unsigned'(sa >>> sh)) & 255;
            9: e.res = (sa < sb) ? 1 : 0;
            10: e.res = (a < b) ? 1 : 0;
            11: e.res = b;
            default: e.res = 0;
        endcase
        e.zf     = (e.res == 0) ? 1 : 0;
        e.addRes = (aa + ab) % 256;
        return e;
    endfunction

    function automatic exp_t resetState();
        exp_t e;
        e.res = 0; e.zf = 1; e.ovf = 0; e.addRes = 0;
        return e;
    endfunction

    task automatic compareField(string name, int unsigned actual, int unsigned expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput(exp_t e);
        compareField("out0",    int'(out0),    e.res);
        compareField("zero",    int'(zero),    e.zf);
        compareField("ovrflw",  int'(ovrflw),  e.ovf);
        compareField("add_out", int'(add_out), e.addRes);
    endtask

    // Drive one cycle of inputs at the falling edge and record what the next rising edge must produce.
    task automatic applyStimulus(logic rstN, logic e, int unsigned op, int unsigned a,
                                 int unsigned b, int unsigned aa, int unsigned ab);
        @(negedge clk);
        rst_n = rstN;
        en    = e;
        alo   = 4'(op);
        in0   = 8'(a);
        in1   = 8'(b);
        add_a = 8'(aa);
        add_b = 8'(ab);
        if (!rstN)  model = resetState();
        else if (e) model = refModel(op, a, b, aa, ab);
        scoreQ.push_back(model);
    endtask

    task automatic asyncReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput(resetState());
        model = resetState();
        scoreQ.push_back(model);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
        end
    end

    initial begin : driver
        rst_n = 1'b1; en = 1'b0; alo = '0; in0 = '0; in1 = '0; add_a = '0; add_b = '0;
        #3 rst_n = 1'b0;
        #1 checkOutput(resetState());
        model = resetState();
        applyStimulus(1'b0, 1'b1, 0, 9, 9, 1, 1);
        applyStimulus(1'b1, 1'b1, 0, 3, 2, 0, 0);

        applyStimulus(1'b1, 1'b1, 0, 255, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 0, 127, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 0, 128, 128, 0, 0);
        applyStimulus(1'b1, 1'b1, 1, 2, 3, 0, 0);
        applyStimulus(1'b1, 1'b1, 1, 3, 3, 0, 0);
        applyStimulus(1'b1, 1'b1, 1, 128, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 12, 255, 77, 0, 0);
        applyStimulus(1'b1, 1'b1, 13, 0, 77, 0, 0);
        applyStimulus(1'b1, 1'b1, 13, 128, 0, 0, 0);

        for (int op = 0; op < 2; op++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    applyStimulus(1'b1, 1'b1, op, a, b, a, b);

        applyStimulus(1'b1, 1'b1, 6, 8'h81, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 8, 8'h81, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 7, 8'h81, 8'hF9, 0, 0);
        applyStimulus(1'b1, 1'b1, 9, 8'hFF, 8'h01, 0, 0);
        applyStimulus(1'b1, 1'b1, 10, 8'hFF, 8'h01, 0, 0);
        applyStimulus(1'b1, 1'b1, 5, 8'hFF, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 11, 1, 8'hA5, 0, 0);
        applyStimulus(1'b1, 1'b1, 14, 8'h55, 8'h33, 0, 0);
        applyStimulus(1'b1, 1'b1, 15, 8'h55, 8'h33, 0, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                applyStimulus(1'b1, 1'b1, 4, a, b, a, b);
        applyStimulus(1'b1, 1'b1, 3, 8'h0F, 8'hF0, 200, 100);

        applyStimulus(1'b1, 1'b1, 0, 100, 50, 10, 20);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1 + i, 200 + i, 7 * i, 99, 98 + i);
        applyStimulus(1'b1, 1'b1, 2, 8'hF0, 8'h3C, 5, 6);

        asyncReset();
        applyStimulus(1'b0, 1'b1, 0, 50, 60, 70, 80);
        applyStimulus(1'b1, 1'b1, 1, 10, 20, 30, 40);

        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, ($urandom_range(0, 4) != 0), $urandom_range(0, 15),
                          $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255));

        @(posedge clk);
        #3;
        assertCount++;
        if (scoreQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", scoreQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/nr_alu.md
Name: nr_alu

Overview:
Registered 8-bit arithmetic/logic unit for the nanoRisk datapath. It also contains the standalone 8-bit adder function used for address/PC increment, exposed as a separate registered output. The block sits between the register-file read ports and the write-back/branch logic. Zero and overflow flags feed branch decisions.

Parameters:
WIDTH, 8, operand/result width in bits; all width rules below are stated for WIDTH=8.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  capture enable; when low, all output registers hold their values
in0  input  8  operand A
in1  input  8  operand B
alo  input  4  operation select code
add_a  input  8  adder operand A (independent adder path)
add_b  input  8  adder operand B
out0  output  8  registered ALU result
zero  output  1  registered flag: 1 when the captured out0 equals 0
ovrflw  output  2  registered flags: [0] unsigned carry/borrow, [1] signed two's-complement overflow
add_out  output  8  registered (add_a + add_b) mod 256

Behaviour:
- One clock, rst_n is asynchronous and active-low. All registers use the same clock and reset.
- Reset: out0=0x00, zero=1, ovrflw=2'b00, add_out=0x00; applied immediately on rst_n falling edge, independent of clk.
- Latency: one cycle. On a rising clk edge with rst_n=1 and en=1, results of the current inputs are captured. With en=0, all outputs hold.
- No combinational path from inputs to outputs.
- Opcodes (alo):
  - 0 ADD: in0+in1 mod 256. ovrflw[0]=carry out of bit 7. ovrflw[1]=1 when the operands have equal sign and the result sign differs.
  - 1 SUB: in0-in1 mod 256. ovrflw[0]=borrow (1 when in0<in1 unsigned). ovrflw[1]=1 when the operands have different signs and the result sign differs from in0.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 NOT: ~in0.
  - 6 SLL: in0 << in1[2:0]. 7 SRL: logical right shift. 8 SRA: arithmetic right shift. Shift amount is in1[2:0]; in1[7:3] is ignored.
  - 9 SLT: 0x01 if signed in0 < signed in1, else 0x00.
  - 10 SLTU: 0x01 if unsigned in0 < in1, else 0x00.
  - 11 PASS: in1.
  - 12 INC: in0+1, with flags as ADD using in1 replaced by 1.
  - 13 DEC: in0-1, with flags as SUB using in1 replaced by 1.
  - 14, 15: reserved; result 0x00.
- ovrflw is 2'b00 for every opcode except ADD, SUB, INC, DEC.
- zero is computed from the 8-bit result being captured, for every opcode including reserved ones (reserved gives zero=1).
- Adder path is independent of alo and in0/in1. It captures together with the ALU under en. The carry out of the adder is discarded.
- Wrap-around: all arithmetic is modulo 256, with no saturation.
- Changing alo or operands between edges affects only the next capture. No internal state other than the output registers.
- Reset asserted mid-stream clears outputs at once. The first capture after rst_n deasserts uses the inputs present at that edge.

Test Plan:
- Reset: drive rst_n=0 asynchronously between edges -> out0=0, zero=1, ovrflw=00, add_out=0 immediately. Release and clock alo=0, in0=3, in1=2 -> out0=5, zero=0, ovrflw=00.
- ADD boundaries: in0=255, in1=1, alo=0 -> out0=0, zero=1, ovrflw=01. in0=127, in1=1 -> out0=128, ovrflw=10. in0=128, in1=128 -> out0=0, zero=1, ovrflw=11.
- SUB boundaries: alo=1, in0=2, in1=3 -> out0=255, ovrflw=01. in0=3, in1=3 -> out0=0, zero=1, ovrflw=00. in0=128, in1=1 -> out0=127, ovrflw=10.
- Sweep in0, in1 over 0..3 for alo 0 and 1, checking out0 and flags each cycle one clock after the inputs are applied. Spot-check logic/shift ops: alo=6, in0=0x81, in1=1 -> 0x02. alo=8, in0=0x81, in1=1 -> 0xC0. alo=9, in0=0xFF, in1=0x01 -> 0x01. alo=10 with the same operands -> 0x00.
- Adder sweep: add_a, add_b over 0..15 -> add_out equals the sum one cycle later. add_a=200, add_b=100 -> add_out=44.
- Enable hold: set en=0, change all inputs, clock 3 times -> all outputs unchanged. Set en=1 -> new result after one edge.
